prio_enc_rr: RTL and testbench
==============================

Name: prio_enc_rr

Overview:
- Parametrised, registered successor to the 16-bit priority encoder.
- Takes a WIDTH-bit request vector and produces the winning index, a one-hot grant and a "none" flag.
- Two modes:
  - fixed priority: highest index wins;
  - round-robin: a rotating pointer sets where the search starts.
- Output sits in a valid/ready register stage, so the block can sit between request sources and a downstream consumer that applies backpressure.

Parameters:
- WIDTH, 16, number of request lines (2..64).
- IDX_W, $clog2(WIDTH), width of the grant index.
- CNT_W, 16, width of the statistics counter (used only with PRIO_ENC_STATS_EN).

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- req_i, input, WIDTH, request vector; bit k = request k.
- req_valid_i, input, 1, req_i and mode_rr_i are valid this cycle.
- req_ready_o, output, 1, block accepts a request this cycle.
- mode_rr_i, input, 1, 0 = fixed priority (highest index wins), 1 = round-robin.
- grant_idx_o, output, IDX_W, index of the granted request.
- grant_oh_o, output, WIDTH, one-hot grant (all zero when there is no request).
- grant_none_o, output, 1, accepted request vector was all zero.
- out_valid_o, output, 1, grant outputs hold a valid result.
- out_ready_i, input, 1, downstream consumes the result this cycle.
- stat_cnt_o, output, CNT_W, accepted-grant counter (present only with PRIO_ENC_STATS_EN).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets: out_valid_o=0, grant_idx_o=0, grant_oh_o=0, grant_none_o=0, rr_ptr=0, stat_cnt_o=0.
- Reset overrides everything in the same cycle. A result in flight is discarded and is not consumed.
- req_ready_o = !out_valid_o || out_ready_i. It is combinational from out_ready_i; there is no other combinational path to the outputs.
- Accept happens when req_valid_i && req_ready_o.
  - Latency is one cycle: the grant is visible on the next edge with out_valid_o=1.
  - Full throughput is one request per cycle under continuous out_ready_i=1.
- Hold: while out_valid_o=1 && out_ready_i=0, all grant outputs stay stable and no new request is accepted.
- Consume without new accept: out_valid_o goes to 0 on the next edge and the grant outputs hold their last values.
- Fixed mode (mode_rr_i=0):
  - The highest set bit of req_i wins.
  - rr_ptr is unchanged.
- Round-robin mode (mode_rr_i=1):
  - Search order is rr_ptr, rr_ptr+1, …, WIDTH-1, 0, …, rr_ptr-1; the first set bit wins.
  - On accept with grant k, rr_ptr <= (k+1) mod WIDTH. When k=WIDTH-1 the pointer wraps to 0.
- Zero request:
  - grant_none_o=1, grant_idx_o=0, grant_oh_o=0, out_valid_o=1.
  - rr_ptr is unchanged.
- Mode is sampled per accepted request. Switching mode does not reset rr_ptr.
- Non-power-of-two WIDTH: rr_ptr wraps at WIDTH, never at 2^IDX_W.
- Invariant: grant_oh_o has exactly one bit set whenever grant_none_o=0, and that bit equals grant_idx_o.

Optional Feature:
- Macro: PRIO_ENC_STATS_EN.
- Defined:
  - stat_cnt_o exists.
  - It increments by 1 on every accepted request with a non-zero req_i.
  - It saturates at 2^CNT_W-1 and clears only on rst.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package prio_enc_pkg holds:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - default WIDTH and CNT_W constants;
  - a function computing the wrapped pointer increment.
- Sub-module prio_enc_find:
  - purely combinational first-set search;
  - inputs: request vector, start pointer, mode;
  - outputs: index, one-hot, none.
- The top level holds the output register, the handshake, rr_ptr and the counter.

Test Plan (WIDTH=16):
- Fixed mode, out_ready_i=1:
  - req_i=0x8000 → next cycle grant_idx_o=15, grant_oh_o=0x8000;
  - then req_i=0x0080 → grant_idx_o=7, grant_oh_o=0x0080.
- Round-robin mode, req_i=0x8081 held for 4 accepts → grant_idx_o sequence 0, 7, 15, 0; rr_ptr wraps from 0 through 1, 8, back to 0.
- Zero request: req_i=0x0000 → grant_none_o=1, grant_oh_o=0, grant_idx_o=0, out_valid_o=1; the following round-robin grant is unchanged by it.
- Backpressure: accept 0x0010, then out_ready_i=0 for 3 cycles with new req_valid_i=1 req_i=0x0100.
  - req_ready_o=0 and grant_idx_o=4 held throughout.
  - After out_ready_i=1 the next accepted result is 8.
- Reset mid-operation: rst=1 while out_valid_o=1 and rr_ptr=8 → next cycle out_valid_o=0, all outputs 0; round-robin restarts, so 0x8081 → 0.
- With PRIO_ENC_STATS_EN and CNT_W=2: 5 non-zero accepts plus 1 zero accept → stat_cnt_o reaches 3 and stays at 3.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
// Mode encoding, default sizes and the wrapped round-robin pointer step.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 16;

    // Wraps at the request count, not at a power of two, so odd widths stay in range.
    function automatic int unsigned ptr_wrap_inc(input int unsigned k, input int unsigned width);
        return (k + 1 >= width) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/prio_enc_find.sv
// Combinational first-set search: highest index in fixed mode, or the first
// set bit at/after the start pointer (wrapping) in round-robin mode.
module prio_enc_find
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic             mode,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] oh,
    output logic             none
);

    logic [IDX_W-1:0] fix_idx;
    logic [IDX_W-1:0] wrap_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             wrap_hit;

    always_comb begin
        fix_idx  = '0;
        wrap_idx = '0;
        lo_idx   = '0;
        wrap_hit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) fix_idx = IDX_W'(i);
        end
        // Descending scan: the last hit kept is the lowest, both overall and at/above start.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (i >= int'(start)) begin
                    wrap_idx = IDX_W'(i);
                    wrap_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        none = ~|req;
        if (none) begin
            idx = '0;
        end else if (mode == MODE_FIXED) begin
            idx = fix_idx;
        end else begin
            idx = wrap_hit ? wrap_idx : lo_idx;
        end
        oh = none ? '0 : (WIDTH'(1) << idx);
    end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered priority encoder with fixed / round-robin modes behind a valid/ready
// output stage. Optional accepted-grant counter enabled by PRIO_ENC_STATS_EN.
module prio_enc_rr
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             mode_rr_i,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic [WIDTH-1:0] grant_oh_o,
    output logic             grant_none_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
`ifdef PRIO_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_cnt_o
`endif
);

    if (WIDTH < 2 || WIDTH > 64 || IDX_W < $clog2(WIDTH) || CNT_W < 1) begin : g_bad_params
        $error("prio_enc_rr: WIDTH must be 2..64, IDX_W >= clog2(WIDTH), CNT_W >= 1");
    end

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] find_idx;
    logic [WIDTH-1:0] find_oh;
    logic             find_none;
    logic             accept;

    prio_enc_find #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_find (
        .req   (req_i),
        .start (rr_ptr),
        .mode  (mode_rr_i),
        .idx   (find_idx),
        .oh    (find_oh),
        .none  (find_none)
    );

    // Handshake: a request transfers when req_valid_i && req_ready_o; a result
    // transfers when out_valid_o && out_ready_i. The stage frees up in the same
    // cycle its result is consumed, so req_ready_o is the only comb path.
    assign req_ready_o = !out_valid_o || out_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o  <= 1'b0;
            grant_idx_o  <= '0;
            grant_oh_o   <= '0;
            grant_none_o <= 1'b0;
            rr_ptr       <= '0;
        end else if (accept) begin
            out_valid_o  <= 1'b1;
            grant_idx_o  <= find_idx;
            grant_oh_o   <= find_oh;
            grant_none_o <= find_none;
            if (!find_none && mode_rr_i == MODE_RR) begin
                rr_ptr <= IDX_W'(ptr_wrap_inc(32'(find_idx), WIDTH));
            end
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

`ifdef PRIO_ENC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt_o <= '0;
        end else if (accept && !find_none && stat_cnt_o != '1) begin
            stat_cnt_o <= stat_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed bench for prio_enc_rr (WIDTH=16): a spec-level model checked every
// cycle plus a queue of hand-computed grants checked as each result is consumed.
module tb_prio_enc_rr;

    localparam int W     = 16;
    localparam int IW    = 4;
    localparam int CW    = 2;
    localparam int EXP_W = 1 + W + IW;

    logic          clk;
    logic          rst;
    logic [W-1:0]  req_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          mode_rr_i;
    logic [IW-1:0] grant_idx_o;
    logic [W-1:0]  grant_oh_o;
    logic          grant_none_o;
    logic          out_valid_o;
    logic          out_ready_i;
`ifdef PRIO_ENC_STATS_EN
    logic [CW-1:0] stat_cnt_o;
`endif

    prio_enc_rr #(
        .WIDTH (W),
        .IDX_W (IW),
        .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .mode_rr_i    (mode_rr_i),
        .grant_idx_o  (grant_idx_o),
        .grant_oh_o   (grant_oh_o),
        .grant_none_o (grant_none_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i)
`ifdef PRIO_ENC_STATS_EN
        ,
        .stat_cnt_o   (stat_cnt_o)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit started = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Model state
    bit          m_valid;
    int          m_idx;
    logic [W-1:0] m_oh;
    bit          m_none;
    int          m_ptr;
    int          m_cnt;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner from the rules: fixed = highest set bit, rr = first set bit walking from ptr.
    function automatic int model_pick(input logic [W-1:0] r, input bit rr, input int ptr);
        if (r == '0) return -1;
        if (!rr) return $clog2(32'(r) + 1) - 1;
        for (int off = 0; off < W; off++) begin
            if (r[(ptr + off) % W]) return (ptr + off) % W;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int k;
        if (rst) begin
            m_valid = 0; m_idx = 0; m_oh = '0; m_none = 0; m_ptr = 0; m_cnt = 0;
            exp_q.delete();
            started = 1;
        end else if (req_valid_i && (!m_valid || out_ready_i)) begin
            k = model_pick(req_i, mode_rr_i, m_ptr);
            m_valid = 1;
            m_none  = (k < 0);
            m_idx   = (k < 0) ? 0 : k;
            m_oh    = (k < 0) ? '0 : (W'(1) << k);
            if (k >= 0 && mode_rr_i) m_ptr = (k + 1) % W;
            if (k >= 0 && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end else if (out_ready_i) begin
            m_valid = 0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (started && !rst) begin
            check("out_valid", out_valid_o, m_valid);
            check("req_ready", req_ready_o, !m_valid || out_ready_i);
            check("grant_idx", grant_idx_o, m_idx);
            check("grant_oh", grant_oh_o, m_oh);
            check("grant_none", grant_none_o, m_none);
`ifdef PRIO_ENC_STATS_EN
            check("stat_cnt", stat_cnt_o, m_cnt);
`endif
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_result: got idx %0d with no expectation queued", grant_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_grant", {grant_none_o, grant_oh_o, grant_idx_o}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] r, input logic m, input int e_idx,
                        input logic [W-1:0] e_oh, input logic e_none);
        bit acc = 0;
        exp_q.push_back({e_none, e_oh, IW'(e_idx)});
        req_valid_i = 1'b1;
        req_i       = r;
        mode_rr_i   = m;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = req_ready_o;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: req %0h not accepted within 50 cycles", r);
        end
        req_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; req_i = '0; req_valid_i = 1'b0; mode_rr_i = 1'b0; out_ready_i = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid_o, 0);
        check("rst_idx", grant_idx_o, 0);
        check("rst_oh", grant_oh_o, 0);
        check("rst_none", grant_none_o, 0);
        check("rst_ready", req_ready_o, 1);
        @(posedge clk); #1;

        // fixed priority
        send(16'h8000, 1'b0, 15, 16'h8000, 1'b0);
        send(16'h0080, 1'b0, 7, 16'h0080, 1'b0);
        // round-robin walk with wrap: ptr 0 -> 1 -> 8 -> 0 -> 1
        send(16'h8081, 1'b1, 0, 16'h0001, 1'b0);
        send(16'h8081, 1'b1, 7, 16'h0080, 1'b0);
        send(16'h8081, 1'b1, 15, 16'h8000, 1'b0);
        send(16'h8081, 1'b1, 0, 16'h0001, 1'b0);
        // zero request leaves ptr at 1
        send(16'h0000, 1'b1, 0, 16'h0000, 1'b1);
        send(16'h8081, 1'b1, 7, 16'h0080, 1'b0);
        idle(2);

        // backpressure: 4 held for 3 cycles, then 8 accepted
        out_ready_i = 1'b1;
        send(16'h0010, 1'b0, 4, 16'h0010, 1'b0);
        out_ready_i = 1'b0;
        req_valid_i = 1'b1; req_i = 16'h0100; mode_rr_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_ready", req_ready_o, 0);
            check("hold_idx", grant_idx_o, 4);
            check("hold_valid", out_valid_o, 1);
            @(posedge clk); #1;
        end
        out_ready_i = 1'b1;
        send(16'h0100, 1'b0, 8, 16'h0100, 1'b0);

        // reset while a result is in flight and rr_ptr = 8
        out_ready_i = 1'b0;
        @(negedge clk);
        check("pre_rst_idx", grant_idx_o, 8);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", out_valid_o, 0);
        check("mid_rst_idx", grant_idx_o, 0);
        check("mid_rst_oh", grant_oh_o, 0);
        check("mid_rst_none", grant_none_o, 0);
        @(posedge clk); #1;
        send(16'h8081, 1'b1, 0, 16'h0001, 1'b0);

        // boundaries and mode switching (ptr carried across modes)
        send(16'h0001, 1'b0, 0, 16'h0001, 1'b0);
        send(16'hFFFF, 1'b0, 15, 16'h8000, 1'b0);
        send(16'hFFFF, 1'b1, 1, 16'h0002, 1'b0);
        send(16'hFFFF, 1'b1, 2, 16'h0004, 1'b0);
        send(16'h0000, 1'b1, 0, 16'h0000, 1'b1);
        send(16'h0003, 1'b0, 1, 16'h0002, 1'b0);
        send(16'h0003, 1'b1, 0, 16'h0001, 1'b0);
        send(16'h4000, 1'b1, 14, 16'h4000, 1'b0);
        send(16'h8001, 1'b1, 15, 16'h8000, 1'b0);
        send(16'h8001, 1'b1, 0, 16'h0001, 1'b0);
        idle(3);

        check("sb_drained", exp_q.size(), 0);
`ifdef PRIO_ENC_STATS_EN
        check("stat_saturated", stat_cnt_o, 3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
